vec_loader_36: RTL and testbench

VEC_LOADER_36 -- requirements
Module: vec_loader_36

---
 rtl/vec_loader_36_pkg.sv | 18 +
 rtl/vec_loader_36.sv | 119 +++++++++++
 tb/tb_vec_loader_36.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/vec_loader_36_pkg.sv
// vec_loader_36_pkg
// Shared types and constants for the vector loader that feeds the
// dot-product unit.
//   state_t           : FILL collects element pairs; ISSUE drives the load strobe.
//   DATA_LEN_FALLBACK : default element width, matching the project-wide
//                       data_len constant.
//   LD_CNT_W          : width of the load-cycle counter (LOAD_CYCLES is 1..15).
package vec_loader_36_pkg;

  typedef enum logic {
    FILL  = 1'b0,
    ISSUE = 1'b1
  } state_t;

  localparam int DATA_LEN_FALLBACK = 16;
  localparam int LD_CNT_W          = 4;

endpackage

// File: rtl/vec_loader_36.sv
// vec_loader_36
// Gathers N signed element pairs into two packed vectors and hands them to
// the dot-product consumer by holding load high for LOAD_CYCLES cycles.
// A flush issues a partial vector with the unwritten slots left at zero.
//
// Ports
//   clk      : single clock, rising edge
//   rst_n    : synchronous active-low reset
//   in_valid : element pair present on in_d1/in_d2
//   in_ready : pair accepted this cycle (high only while collecting)
//   in_d1    : operand-1 element
//   in_d2    : operand-2 element
//   flush    : zero-pad the partial vector and issue it
//   d1, d2   : packed vectors, element i at [i*DATA_LEN +: DATA_LEN]
//   load     : vector valid strobe
//   vec_cnt  : vectors issued since reset, wraps
module vec_loader_36
  import vec_loader_36_pkg::*;
#(
  parameter int N = 36,
  parameter int DATA_LEN = DATA_LEN_FALLBACK,
  parameter int LOAD_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_LEN-1:0]   in_d1,
  input  logic [DATA_LEN-1:0]   in_d2,
  input  logic                  flush,
  output logic [N*DATA_LEN-1:0] d1,
  output logic [N*DATA_LEN-1:0] d2,
  output logic                  load,
  output logic [15:0]           vec_cnt
);

  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0]    LAST_IDX = IDX_W'(N - 1);
  localparam logic [LD_CNT_W-1:0] LAST_LD  = LD_CNT_W'(LOAD_CYCLES - 1);

  state_t              state;
  state_t              state_next;
  logic [IDX_W-1:0]    idx;
  logic [LD_CNT_W-1:0] ld_cnt;
  logic [N*DATA_LEN-1:0] d1_q;
  logic [N*DATA_LEN-1:0] d2_q;
  logic [15:0]         vec_cnt_q;
  logic                transfer;
  logic                issue_start;
  logic                issue_end;

  // Next-state and handshake decode. A flush only issues when there is
  // something to issue: either earlier slots are filled or an element is
  // landing in the same cycle. A flush on the final transfer folds into
  // the normal full-vector issue, so only one vector goes out.
  always_comb begin
    state_next  = state;
    in_ready    = 1'b0;
    load        = 1'b0;
    transfer    = 1'b0;
    issue_start = 1'b0;
    issue_end   = 1'b0;
    case (state)
      FILL: begin
        in_ready    = rst_n;
        transfer    = in_valid && rst_n;
        issue_start = (transfer && (idx == LAST_IDX)) ||
                      (flush && ((idx != '0) || transfer));
        if (issue_start) state_next = ISSUE;
      end
      ISSUE: begin
        load      = 1'b1;
        issue_end = (ld_cnt == LAST_LD);
        if (issue_end) state_next = FILL;
      end
      default: state_next = FILL;
    endcase
  end

  // State register and datapath. The vectors are cleared on the edge that
  // leaves ISSUE, so the consumer sees them stable for every load cycle and
  // the next vector starts from an all-zero image.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= FILL;
      idx       <= '0;
      ld_cnt    <= '0;
      d1_q      <= '0;
      d2_q      <= '0;
      vec_cnt_q <= '0;
    end else begin
      state <= state_next;
      if (transfer) begin
        d1_q[int'(idx)*DATA_LEN +: DATA_LEN] <= in_d1;
        d2_q[int'(idx)*DATA_LEN +: DATA_LEN] <= in_d2;
      end
      if (issue_start) begin
        idx       <= '0;
        ld_cnt    <= '0;
        vec_cnt_q <= vec_cnt_q + 16'd1;
      end else if (transfer) begin
        idx <= idx + IDX_W'(1);
      end
      if (state == ISSUE) begin
        if (issue_end) begin
          d1_q <= '0;
          d2_q <= '0;
        end else begin
          ld_cnt <= ld_cnt + LD_CNT_W'(1);
        end
      end
    end
  end

  assign d1      = d1_q;
  assign d2      = d2_q;
  assign vec_cnt = vec_cnt_q;

endmodule

// File: tb/tb_vec_loader_36.sv
// tb_vec_loader_36
// Directed bench for vec_loader_36. One instance uses the default two-cycle
// load; a second instance with LOAD_CYCLES=1 takes a randomly gapped stream.
// Inputs change 1 time unit after each rising edge and outputs are sampled
// there as well, so every sample reflects the state after that edge.
module tb_vec_loader_36;

  localparam int N  = 36;
  localparam int DL = 16;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [DL-1:0] in_d1;
  logic [DL-1:0] in_d2;
  logic          flush;
  logic [N*DL-1:0] d1;
  logic [N*DL-1:0] d2;
  logic          load;
  logic [15:0]   vec_cnt;

  logic          in_valid1;
  logic          in_ready1;
  logic [DL-1:0] in_d1_1;
  logic [DL-1:0] in_d2_1;
  logic [N*DL-1:0] d1_1;
  logic [N*DL-1:0] d2_1;
  logic          load1;
  logic [15:0]   vec_cnt1;
  logic          flush1;

  int errors;
  int checks;

  vec_loader_36 #(.N(N), .DATA_LEN(DL), .LOAD_CYCLES(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_d1(in_d1), .in_d2(in_d2), .flush(flush),
    .d1(d1), .d2(d2), .load(load), .vec_cnt(vec_cnt)
  );

  vec_loader_36 #(.N(N), .DATA_LEN(DL), .LOAD_CYCLES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
    .in_d1(in_d1_1), .in_d2(in_d2_1), .flush(flush1),
    .d1(d1_1), .d2(d2_1), .load(load1), .vec_cnt(vec_cnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle just past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DL-1:0] slot(input logic [N*DL-1:0] v, input int i);
    return v[i*DL +: DL];
  endfunction

  // Reset holds everything at zero and keeps in_ready low.
  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    checks++; if (load !== 1'b0) begin errors++; $display("[TB] FAIL reset_load: got %0b expected 0", load); end
    checks++; if (vec_cnt !== 16'd0) begin errors++; $display("[TB] FAIL reset_vec_cnt: got %0d expected 0", vec_cnt); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_in_ready: got %0b expected 0", in_ready); end
    checks++; if (d1 !== '0 || d2 !== '0) begin errors++; $display("[TB] FAIL reset_data: d1/d2 not zero"); end
    rst_n = 1'b1;
    step();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_release_ready: got %0b expected 1", in_ready); end
  endtask

  // 36 pairs k / -k back to back; load occupies cycles 37 and 38.
  task automatic test_full_vector();
    int early;
    early = 0;
    for (int k = 0; k < N; k++) begin
      in_valid = 1'b1; in_d1 = DL'(k); in_d2 = DL'(-k);
      step();
      if (k < N - 1 && load) early++;
    end
    in_valid = 1'b0;
    checks++; if (early !== 0) begin errors++; $display("[TB] FAIL full_early_load: got %0d expected 0", early); end
    checks++; if (load !== 1'b1) begin errors++; $display("[TB] FAIL full_load_c37: got %0b expected 1", load); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL full_ready_issue: got %0b expected 0", in_ready); end
    checks++; if (slot(d1, 5) !== DL'(5)) begin errors++; $display("[TB] FAIL full_d1_slot5: got %0h expected %0h", slot(d1, 5), DL'(5)); end
    checks++; if (slot(d2, 5) !== DL'(-5)) begin errors++; $display("[TB] FAIL full_d2_slot5: got %0h expected %0h", slot(d2, 5), DL'(-5)); end
    checks++; if (slot(d1, 35) !== DL'(35)) begin errors++; $display("[TB] FAIL full_d1_slot35: got %0h expected %0h", slot(d1, 35), DL'(35)); end
    checks++; if (vec_cnt !== 16'd1) begin errors++; $display("[TB] FAIL full_vec_cnt: got %0d expected 1", vec_cnt); end
    step();
    checks++; if (load !== 1'b1) begin errors++; $display("[TB] FAIL full_load_c38: got %0b expected 1", load); end
    step();
    checks++; if (load !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("[TB] FAIL full_load_end: load=%0b ready=%0b expected 0/1", load, in_ready); end
    checks++; if (d1 !== '0) begin errors++; $display("[TB] FAIL full_cleared: d1 not zero after issue"); end
  endtask

  // Ten pairs then a flush; slots 10..35 must read zero.
  task automatic test_flush_partial();
    int nz;
    for (int k = 0; k < 10; k++) begin
      in_valid = 1'b1; in_d1 = DL'(100 + k); in_d2 = DL'(-(100 + k));
      step();
    end
    in_valid = 1'b0;
    checks++; if (load !== 1'b0) begin errors++; $display("[TB] FAIL flush_pre_load: got %0b expected 0", load); end
    flush = 1'b1;
    step();
    flush = 1'b0;
    nz = 0;
    for (int i = 10; i < N; i++) if (slot(d1, i) !== '0 || slot(d2, i) !== '0) nz++;
    checks++; if (load !== 1'b1) begin errors++; $display("[TB] FAIL flush_load: got %0b expected 1", load); end
    checks++; if (nz !== 0) begin errors++; $display("[TB] FAIL flush_zero_pad: got %0d nonzero slots expected 0", nz); end
    checks++; if (slot(d1, 9) !== DL'(109) || slot(d2, 9) !== DL'(-109)) begin errors++; $display("[TB] FAIL flush_slot9: got %0h/%0h expected %0h/%0h", slot(d1, 9), slot(d2, 9), DL'(109), DL'(-109)); end
    checks++; if (vec_cnt !== 16'd2) begin errors++; $display("[TB] FAIL flush_vec_cnt: got %0d expected 2", vec_cnt); end
    step();
    checks++; if (load !== 1'b1) begin errors++; $display("[TB] FAIL flush_load2: got %0b expected 1", load); end
    step();
    checks++; if (load !== 1'b0) begin errors++; $display("[TB] FAIL flush_load_end: got %0b expected 0", load); end
  endtask

  // in_valid held high across ISSUE: two stalled cycles and no lost element.
  task automatic test_back_to_back();
    int  j;
    int  low;
    bit  rdy;
    bit  seen;
    logic [DL-1:0] a0;
    logic [DL-1:0] a35;
    j = 0; low = 0; seen = 1'b0; a0 = '0; a35 = '0;
    for (int c = 0; c < 100 && j < N + 1; c++) begin
      in_valid = 1'b1; in_d1 = DL'(200 + j); in_d2 = DL'(-(200 + j));
      rdy = in_ready;
      step();
      if (rdy) j++; else low++;
      if (load && !seen) begin seen = 1'b1; a0 = slot(d1, 0); a35 = slot(d1, 35); end
    end
    in_valid = 1'b0;
    checks++; if (j !== N + 1) begin errors++; $display("[TB] FAIL b2b_timeout: accepted %0d expected %0d", j, N + 1); end
    checks++; if (low !== 2) begin errors++; $display("[TB] FAIL b2b_stall: got %0d expected 2", low); end
    checks++; if (a0 !== DL'(200) || a35 !== DL'(235)) begin errors++; $display("[TB] FAIL b2b_first_vec: got %0h/%0h expected %0h/%0h", a0, a35, DL'(200), DL'(235)); end
    flush = 1'b1;
    step();
    flush = 1'b0;
    checks++; if (load !== 1'b1) begin errors++; $display("[TB] FAIL b2b_second_load: got %0b expected 1", load); end
    checks++; if (slot(d1, 0) !== DL'(236) || slot(d2, 0) !== DL'(-236)) begin errors++; $display("[TB] FAIL b2b_slot0: got %0h/%0h expected %0h/%0h", slot(d1, 0), slot(d2, 0), DL'(236), DL'(-236)); end
    checks++; if (slot(d1, 1) !== '0) begin errors++; $display("[TB] FAIL b2b_slot1: got %0h expected 0", slot(d1, 1)); end
    checks++; if (vec_cnt !== 16'd4) begin errors++; $display("[TB] FAIL b2b_vec_cnt: got %0d expected 4", vec_cnt); end
    step();
    step();
  endtask

  // Flush with an empty vector is ignored; flush on the 36th transfer issues once.
  task automatic test_flush_edges();
    int loads;
    loads = 0;
    flush = 1'b1;
    step();
    flush = 1'b0;
    if (load) loads++;
    step(); if (load) loads++;
    step(); if (load) loads++;
    checks++; if (loads !== 0) begin errors++; $display("[TB] FAIL idle_flush_load: got %0d expected 0", loads); end
    checks++; if (vec_cnt !== 16'd4) begin errors++; $display("[TB] FAIL idle_flush_vec_cnt: got %0d expected 4", vec_cnt); end
    for (int k = 0; k < N; k++) begin
      in_valid = 1'b1; in_d1 = DL'(400 + k); in_d2 = DL'(-(400 + k));
      flush = (k == N - 1);
      step();
    end
    in_valid = 1'b0; flush = 1'b0;
    checks++; if (load !== 1'b1) begin errors++; $display("[TB] FAIL last_flush_load: got %0b expected 1", load); end
    checks++; if (slot(d1, 35) !== DL'(435)) begin errors++; $display("[TB] FAIL last_flush_slot35: got %0h expected %0h", slot(d1, 35), DL'(435)); end
    checks++; if (vec_cnt !== 16'd5) begin errors++; $display("[TB] FAIL last_flush_vec_cnt: got %0d expected 5", vec_cnt); end
    loads = 1;
    for (int c = 0; c < 5; c++) begin
      step();
      if (load) loads++;
    end
    checks++; if (loads !== 2) begin errors++; $display("[TB] FAIL last_flush_cycles: got %0d expected 2", loads); end
  endtask

  // Reset after 20 transfers discards them; the next vector holds only new data.
  task automatic test_reset_mid();
    int early;
    for (int k = 0; k < 20; k++) begin
      in_valid = 1'b1; in_d1 = DL'(7); in_d2 = DL'(7);
      step();
    end
    in_valid = 1'b0;
    rst_n = 1'b0;
    step();
    checks++; if (d1 !== '0 || d2 !== '0 || load !== 1'b0) begin errors++; $display("[TB] FAIL midreset_outputs: load=%0b, data not all zero", load); end
    checks++; if (vec_cnt !== 16'd0 || in_ready !== 1'b0) begin errors++; $display("[TB] FAIL midreset_cnt_ready: got %0d/%0b expected 0/0", vec_cnt, in_ready); end
    rst_n = 1'b1;
    early = 0;
    for (int k = 0; k < N; k++) begin
      in_valid = 1'b1; in_d1 = DL'(300 + k); in_d2 = DL'(-(300 + k));
      step();
      if (k < N - 1 && load) early++;
    end
    in_valid = 1'b0;
    checks++; if (early !== 0) begin errors++; $display("[TB] FAIL midreset_early_load: got %0d expected 0", early); end
    checks++; if (load !== 1'b1 || vec_cnt !== 16'd1) begin errors++; $display("[TB] FAIL midreset_issue: load=%0b cnt=%0d expected 1/1", load, vec_cnt); end
    checks++; if (slot(d1, 0) !== DL'(300) || slot(d2, 19) !== DL'(-319)) begin errors++; $display("[TB] FAIL midreset_data: got %0h/%0h expected %0h/%0h", slot(d1, 0), slot(d2, 19), DL'(300), DL'(-319)); end
    step();
    step();
  endtask

  // LOAD_CYCLES=1 instance with a 50% gapped stream of 72 pairs.
  task automatic test_load1_random();
    int j;
    int loads;
    int vecs;
    int bad;
    int longload;
    bit rdy;
    bit prev;
    j = 0; loads = 0; vecs = 0; bad = 0; longload = 0; prev = 1'b0;
    for (int c = 0; c < 600 && (j < 2 * N || load1); c++) begin
      in_valid1 = 1'($urandom_range(0, 1));
      in_d1_1 = DL'(500 + j); in_d2_1 = DL'(-(500 + j));
      rdy = in_ready1;
      step();
      if (rdy && in_valid1) j++;
      if (load1) begin
        loads++;
        if (prev) longload++;
        for (int i = 0; i < N; i++) begin
          if (slot(d1_1, i) !== DL'(500 + vecs * N + i)) bad++;
          if (slot(d2_1, i) !== DL'(-(500 + vecs * N + i))) bad++;
        end
        vecs++;
      end
      prev = load1;
    end
    in_valid1 = 1'b0;
    step();
    if (load1) loads++;
    checks++; if (j !== 2 * N) begin errors++; $display("[TB] FAIL load1_timeout: accepted %0d expected %0d", j, 2 * N); end
    checks++; if (loads !== 2 || longload !== 0) begin errors++; $display("[TB] FAIL load1_pulses: got %0d pulses %0d long expected 2/0", loads, longload); end
    checks++; if (bad !== 0) begin errors++; $display("[TB] FAIL load1_packing: got %0d bad slots expected 0", bad); end
    checks++; if (vec_cnt1 !== 16'd2) begin errors++; $display("[TB] FAIL load1_vec_cnt: got %0d expected 2", vec_cnt1); end
  endtask

  initial begin
    errors = 0; checks = 0;
    rst_n = 1'b0; in_valid = 1'b0; in_d1 = '0; in_d2 = '0; flush = 1'b0;
    in_valid1 = 1'b0; in_d1_1 = '0; in_d2_1 = '0; flush1 = 1'b0;
    $display("[TB] starting vec_loader_36 bench");
    test_reset();
    test_full_vector();
    test_flush_partial();
    test_back_to_back();
    test_flush_edges();
    test_reset_mid();
    test_load1_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
